// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Holds the controller FSM encoding, register/NOP constants and the load-use test.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0]  REG_X0    = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic ctrl_stall;
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_flush;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // A load in EX whose destination feeds either source of the instruction in ID.
  function automatic logic is_load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2
  );
    return ex_mem_read && (ex_rd != REG_X0) &&
           ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = &r_cnt;

  // NOTE: sequential state is always updated with <= so every register samples
  // pre-edge values, independent of the order in which always_ff blocks run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/hold/flush controller for the 5-stage RV32I pipeline, with a
// dmem wait-state watchdog and saturating performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             imem_ready,
  output logic             ctrl_stall,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] lu_count
);

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(MEM_TIMEOUT);

  state_e          r_state;
  state_e          w_next_state;
  logic [TO_W-1:0] r_wait_cnt;
  logic            r_mem_err;

  logic  w_freeze;
  logic  w_lu;
  logic  w_rule_br;
  logic  w_rule_lu;
  ctrl_t w_ctrl;

  assign w_freeze = dmem_req && !dmem_ready;
  assign w_lu     = is_load_use(ex_mem_read, ex_rd, id_rs1, id_rs2);

  // ---------------------------------------------------------------------------
  // Wait-state FSM: MEM_WAIT only tracks how long the current access has stalled;
  // the freeze itself is decided purely from the live handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every signal assigned in an always_comb gets a default on entry, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      RUN:      if (w_freeze) w_next_state = MEM_WAIT;
      MEM_WAIT: if (!dmem_req || dmem_ready) w_next_state = RUN;
      default:  w_next_state = RUN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hazard priority: freeze > taken branch > load-use > fetch wait.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ctrl    = CTRL_NONE;
    w_rule_br = 1'b0;
    w_rule_lu = 1'b0;
    if (!rst) begin
      if (w_freeze) begin
        // Any branch or load-use stays parked in its stage until release.
        w_ctrl.pipe_freeze = 1'b1;
        w_ctrl.pc_hold     = 1'b1;
        w_ctrl.if_id_hold  = 1'b1;
      end else if (ex_br_taken) begin
        w_rule_br          = 1'b1;
        w_ctrl.if_id_flush = 1'b1;
        w_ctrl.id_ex_flush = 1'b1;
      end else if (w_lu) begin
        w_rule_lu          = 1'b1;
        w_ctrl.ctrl_stall  = 1'b1;
        w_ctrl.pc_hold     = 1'b1;
        w_ctrl.if_id_hold  = 1'b1;
      end else if (!imem_ready) begin
        w_ctrl.pc_hold     = 1'b1;
        w_ctrl.if_id_flush = 1'b1;
      end
    end
  end

  assign ctrl_stall  = w_ctrl.ctrl_stall;
  assign pc_hold     = w_ctrl.pc_hold;
  assign if_id_hold  = w_ctrl.if_id_hold;
  assign if_id_flush = w_ctrl.if_id_flush;
  assign id_ex_flush = w_ctrl.id_ex_flush;
  assign pipe_freeze = w_ctrl.pipe_freeze;

  // ---------------------------------------------------------------------------
  // Watchdog: counts unanswered MEM_WAIT cycles; the error flag is sticky and
  // deliberately does not break the freeze.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (w_next_state == RUN) begin
      r_wait_cnt <= '0;
    end else if ((r_state == MEM_WAIT) && !dmem_ready && (r_wait_cnt != TIMEOUT_VAL)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_err <= 1'b0;
    end else if (r_wait_cnt == TIMEOUT_VAL) begin
      r_mem_err <= 1'b1;
    end
  end

  assign mem_err = r_mem_err;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_ctrl.pc_hold),
    .cnt (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_rule_br),
    .cnt (flush_count)
  );

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_rule_lu),
    .cnt (lu_count)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage RV32I core.
- Generates every stall, hold and flush control: load-use bubble insertion into ID (drives ID's `ctrl_stall`), branch-taken flush, data-memory wait-state freeze and instruction-fetch wait bubbles.
- Maintains a memory-wait timeout watchdog and saturating performance counters.
- Sits beside the pipeline registers; consumes hazard sources from ID/EX/MEM and the memory handshakes.

Parameters:
- MEM_TIMEOUT, 255: maximum consecutive dmem wait cycles before `mem_err` is raised.
- TO_W, 8: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- ex_rd  in  5  rd of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_br_taken  in  1  branch/jump resolved taken in EX.
- dmem_req  in  1  MEM stage has an active data access.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_ready  in  1  instruction memory returns a valid fetch this cycle.
- ctrl_stall  out  1  to ID: zero all ID control outputs (bubble).
- pc_hold  out  1  PC keeps its value.
- if_id_hold  out  1  IF/ID register keeps its value.
- if_id_flush  out  1  IF/ID register loads a NOP.
- id_ex_flush  out  1  ID/EX register loads a bubble.
- pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB registers keep their values.
- mem_err  out  1  sticky dmem timeout flag.
- stall_cycles  out  CNT_W  count of cycles with `pc_hold`=1.
- flush_count  out  CNT_W  count of branch flush events.
- lu_count  out  CNT_W  count of load-use bubbles.

Behaviour:
- Reset:
  - FSM=RUN, wait counter=0, `mem_err`=0, all counters=0.
  - While `rst`=1, all combinational outputs are forced to 0.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when `dmem_req` & !`dmem_ready`.
  - MEM_WAIT -> RUN on the edge after the cycle where `dmem_ready`=1.
  - `dmem_req` deasserting in MEM_WAIT also returns the FSM to RUN.
- Definitions (in-cycle terms):
  - freeze = `dmem_req` & !`dmem_ready`, valid in either state.
  - lu = `ex_mem_read` & (`ex_rd`!=0) & ((`ex_rd`==`id_rs1`) | (`ex_rd`==`id_rs2`)).
- Priority, highest first; outputs are combinational (zero-cycle latency):
  1. freeze: `pipe_freeze`=`pc_hold`=`if_id_hold`=1. All flushes and `ctrl_stall` are 0. A branch or load-use present stays in place and is handled on the release cycle.
  2. `ex_br_taken`: `if_id_flush`=`id_ex_flush`=1. `pc_hold`=0 (PC takes the target). `ctrl_stall`=0 even if lu holds.
  3. lu: `ctrl_stall`=`pc_hold`=`if_id_hold`=1, lasting exactly one cycle because the bubble clears EX.
  4. !`imem_ready`: `pc_hold`=1 and `if_id_flush`=1; ID/EX is unaffected.
  5. Otherwise all controls are 0.
- Release cycle (`dmem_ready`=1 in MEM_WAIT): freeze=0 in that cycle, so rules 2–4 apply to the current inputs in the same cycle.
- Timeout watchdog:
  - The wait counter increments each MEM_WAIT cycle while !`dmem_ready`, saturating at MEM_TIMEOUT.
  - On reaching MEM_TIMEOUT, `mem_err` sets on the next edge. It is sticky until `rst`.
  - The freeze continues regardless of `mem_err`.
  - The counter clears on exit to RUN.
- Performance counters:
  - Registered, +1 per qualifying cycle, saturating at all-ones.
  - `flush_count` increments on each cycle where rule 2 is active.
  - `lu_count` increments on each cycle where rule 3 is active.
- Reset mid-operation (including during MEM_WAIT or a pending flush): immediate return to reset state; no deferred action survives.

Decomposition:
- Shared package `pipe_pkg`:
  - FSM state enum {RUN, MEM_WAIT}.
  - Constant REG_X0=5'd0.
  - NOP encoding 32'h00000013, used by the IF/ID flush logic.
- One natural sub-module: `sat_counter` (parameter W; inputs clk, rst, inc; output cnt). Instantiated three times.

Test Plan:
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5 -> `ctrl_stall`=`pc_hold`=`if_id_hold`=1 for one cycle. `lu_count`=1. With `ex_rd`=0 instead, no stall.
- Branch over load-use: `ex_br_taken`=1 while lu holds -> `if_id_flush`=`id_ex_flush`=1, `ctrl_stall`=0, `flush_count`=1, `lu_count` unchanged.
- Memory wait, 3 cycles:
  - Stimulus: `dmem_req`=1, `dmem_ready`=0 for 3 cycles, then 1; `ex_br_taken`=1 throughout.
  - Freeze cycles: `pipe_freeze`=1 for 3 cycles with no flush.
  - Release cycle: `pipe_freeze`=0 and both flushes=1.
  - Counts: `stall_cycles`=3, `flush_count`=1.
- Timeout: MEM_TIMEOUT=4, `dmem_ready` held 0 for 10 cycles -> `mem_err` rises after the 4th wait cycle and stays 1 after `dmem_ready` returns. It clears only on `rst`.
- Fetch wait: `imem_ready`=0 for 2 cycles -> `pc_hold`=`if_id_flush`=1, `id_ex_flush`=0, `stall_cycles` += 2.
- Async reset: assert `rst` mid-MEM_WAIT, between clock edges -> all outputs 0 immediately, counters 0. After deassertion with `dmem_req`=0, the FSM is in RUN.
